// File: rtl/rv64_pkg.sv
// Shared RV64 writeback definitions: datapath width, load funct3 codes,
// the hard-wired zero register and the arbiter grant encoding.
package rv64_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Which stream won the most recent transfer; drives round-robin on ties.
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/rv_load_align.sv
// Combinational load extraction: picks the addressed byte/half/word out of
// the raw doubleword, sign- or zero-extends it, and flags misaligned or
// illegal load types.
module rv_load_align
  import rv64_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  logic [XLEN-1:0] sh;
  logic [7:0]      b;
  logic [15:0]     h;
  logic [31:0]     w;

  // Shift the addressed byte down to bit 0; aligned accesses then just slice.
  always_comb begin
    sh = rdata_i >> {addr_lo_i, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
  end

  // Select width/extension and detect misalignment per load type.
  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){b[7]}}, b};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, b};
      F3_LH: begin
        data_o = {{(XLEN-16){h[15]}}, h};
        err_o  = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o = {{(XLEN-16){1'b0}}, h};
        err_o  = addr_lo_i[0];
      end
      F3_LW: begin
        data_o = {{(XLEN-32){w[31]}}, w};
        err_o  = |addr_lo_i[1:0];
      end
      F3_LWU: begin
        data_o = {{(XLEN-32){1'b0}}, w};
        err_o  = |addr_lo_i[1:0];
      end
      F3_LD: begin
        data_o = rdata_i;
        err_o  = |addr_lo_i;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rf_writeback_unit.sv
// Register-file write side: round-robin arbitration between ALU results and
// loads, one registered write per cycle, x0 suppression, load error pulse
// and a saturating count of committed writes.
module rf_writeback_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [2:0]       mem_funct3,
  input  logic [2:0]       mem_addr_lo,
  output logic             RegWrite,
  output logic [4:0]       RD,
  output logic [XLEN-1:0]  WriteData,
  output logic             load_err,
  output logic [CNT_W-1:0] wb_count
);
  import rv64_pkg::*;

  grant_e            grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   ld_data;
  logic              ld_err;

  rv_load_align u_align (
    .rdata_i   (mem_rdata),
    .funct3_i  (mem_funct3),
    .addr_lo_i (mem_addr_lo),
    .data_o    (ld_data),
    .err_o     (ld_err)
  );

  // Arbiter: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    alu_ready = alu_valid && (!mem_valid || (grant_q == GNT_MEM));
    mem_ready = mem_valid && (!alu_valid || (grant_q == GNT_ALU));
  end

  // Next-state for the write port; RD/WriteData hold when nothing is written.
  always_comb begin
    grant_d = grant_q;
    wr_d    = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = 1'b0;
    if (alu_ready) begin
      grant_d = GNT_ALU;
      if (alu_rd != REG_X0) begin
        wr_d   = 1'b1;
        rd_d   = alu_rd;
        data_d = alu_data;
      end
    end else if (mem_ready) begin
      grant_d = GNT_MEM;
      if (ld_err) begin
        err_d = 1'b1;
      end else if (mem_rd != REG_X0) begin
        wr_d   = 1'b1;
        rd_d   = mem_rd;
        data_d = ld_data;
      end
    end
    cnt_d = (wr_d && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  end

  // Output register, grant history and counter; reset starts with MEM as last
  // grant so the first tie goes to the ALU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= GNT_MEM;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      grant_q <= grant_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RegWrite  = wr_q;
  assign RD        = rd_q;
  assign WriteData = data_q;
  assign load_err  = err_q;
  assign wb_count  = cnt_q;

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Self-checking bench for rf_writeback_unit: directed sequences, a load
// extraction vector table and a randomized run against a reference model.
module tb_rf_writeback_unit;

  localparam int CW = 4;

  logic          clk, reset;
  logic          alu_valid, alu_ready;
  logic [4:0]    alu_rd;
  logic [63:0]   alu_data;
  logic          mem_valid, mem_ready;
  logic [4:0]    mem_rd;
  logic [63:0]   mem_rdata;
  logic [2:0]    mem_funct3, mem_addr_lo;
  logic          RegWrite;
  logic [4:0]    RD;
  logic [63:0]   WriteData;
  logic          load_err;
  logic [CW-1:0] wb_count;

  int errors = 0;
  int checks = 0;

  rf_writeback_unit #(.XLEN(64), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData), .load_err(load_err),
    .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Load extraction from first principles: size in bytes, shift and mask.
  function automatic void ref_load(input logic [2:0] f3, input logic [2:0] a,
                                   input logic [63:0] raw,
                                   output logic [63:0] val, output logic err);
    int size;
    logic [63:0] mask;
    size = 1 << f3[1:0];
    err  = (f3 == 3'b111) || ((int'(a) % size) != 0);
    mask = (size == 8) ? {64{1'b1}} : ((64'd1 << (8 * size)) - 64'd1);
    val  = (raw >> (8 * int'(a))) & mask;
    if (!f3[2] && size < 8 && val[8 * size - 1]) val = val | ~mask;
  endfunction

  // Reference model state
  bit          m_last_alu;
  logic        m_wr, m_err;
  logic [4:0]  m_rd;
  logic [63:0] m_wd;
  int          m_cnt;
  bit          m_acc_alu, m_acc_mem;

  task automatic model_reset();
    m_last_alu = 1'b0;
    m_wr = 1'b0; m_err = 1'b0; m_rd = '0; m_wd = '0; m_cnt = 0;
    m_acc_alu = 1'b0; m_acc_mem = 1'b0;
  endtask

  // Called at posedge+1 after inputs are driven: checks readies, advances one
  // clock, then checks the registered outputs against the model.
  task automatic clock_and_check(input string tag);
    logic ar, mr, lerr;
    logic [63:0] lv;
    #1;
    ar = alu_valid && (!mem_valid || !m_last_alu);
    mr = mem_valid && (!alu_valid || m_last_alu);
    check({tag, " alu_ready"}, 64'(alu_ready), 64'(ar));
    check({tag, " mem_ready"}, 64'(mem_ready), 64'(mr));
    m_wr = 1'b0; m_err = 1'b0;
    m_acc_alu = ar; m_acc_mem = mr;
    if (ar) begin
      m_last_alu = 1'b1;
      if (alu_rd != 5'd0) begin m_wr = 1'b1; m_rd = alu_rd; m_wd = alu_data; end
    end else if (mr) begin
      m_last_alu = 1'b0;
      ref_load(mem_funct3, mem_addr_lo, mem_rdata, lv, lerr);
      if (lerr) m_err = 1'b1;
      else if (mem_rd != 5'd0) begin m_wr = 1'b1; m_rd = mem_rd; m_wd = lv; end
    end
    if (m_wr && m_cnt < (1 << CW) - 1) m_cnt++;
    @(posedge clk); #1;
    check({tag, " RegWrite"}, 64'(RegWrite), 64'(m_wr));
    check({tag, " RD"}, 64'(RD), 64'(m_rd));
    check({tag, " WriteData"}, WriteData, m_wd);
    check({tag, " load_err"}, 64'(load_err), 64'(m_err));
    check({tag, " wb_count"}, 64'(wb_count), 64'(m_cnt));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  a;
    logic [63:0] raw;
    logic [63:0] exp;
    logic        exp_err;
  } lvec_t;

  lvec_t tbl[12];
  int    exp_rd[4];
  int    cnt_before;

  initial begin
    tbl[0]  = '{3'b000, 3'd3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    tbl[1]  = '{3'b100, 3'd3, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 1'b0};
    tbl[2]  = '{3'b001, 3'd2, 64'h1122_3344_5566_8899, 64'h0000_0000_0000_5566, 1'b0};
    tbl[3]  = '{3'b101, 3'd6, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001, 1'b0};
    tbl[4]  = '{3'b001, 3'd6, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
    tbl[5]  = '{3'b010, 3'd4, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 1'b0};
    tbl[6]  = '{3'b110, 3'd4, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 1'b0};
    tbl[7]  = '{3'b011, 3'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    tbl[8]  = '{3'b010, 3'd2, 64'h1111_2222_3333_4444, 64'h0, 1'b1};
    tbl[9]  = '{3'b001, 3'd1, 64'h1111_2222_3333_4444, 64'h0, 1'b1};
    tbl[10] = '{3'b011, 3'd4, 64'h1111_2222_3333_4444, 64'h0, 1'b1};
    tbl[11] = '{3'b111, 3'd0, 64'h1111_2222_3333_4444, 64'h0, 1'b1};
    exp_rd = '{1, 2, 1, 2};

    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_rdata = '0; mem_funct3 = '0; mem_addr_lo = '0;
    apply_reset();

    // Reset state and a single ALU write
    check("rst RegWrite", 64'(RegWrite), 64'd0);
    check("rst RD", 64'(RD), 64'd0);
    check("rst WriteData", WriteData, 64'd0);
    check("rst load_err", 64'(load_err), 64'd0);
    check("rst wb_count", 64'(wb_count), 64'd0);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    clock_and_check("alu1");
    check("alu1 RD const", 64'(RD), 64'd5);
    check("alu1 WD const", WriteData, 64'h1234);
    check("alu1 cnt const", 64'(wb_count), 64'd1);
    alu_valid = 1'b0;
    clock_and_check("idle");
    check("idle RD hold", 64'(RD), 64'd5);

    // Round-robin on a sustained tie
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hA;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_rdata = 64'hB; mem_funct3 = 3'b011; mem_addr_lo = 3'd0;
    for (int i = 0; i < 4; i++) begin
      clock_and_check("rr");
      check("rr RD seq", 64'(RD), 64'(exp_rd[i]));
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Load extraction vectors
    for (int i = 0; i < 12; i++) begin
      mem_valid = 1'b1; mem_rd = 5'd7;
      mem_funct3 = tbl[i].f3; mem_addr_lo = tbl[i].a; mem_rdata = tbl[i].raw;
      cnt_before = int'(wb_count);
      clock_and_check("ld");
      check("ld err vec", 64'(load_err), 64'(tbl[i].exp_err));
      if (tbl[i].exp_err) begin
        check("ld err nowrite", 64'(RegWrite), 64'd0);
        check("ld err cnt", 64'(wb_count), 64'(cnt_before));
      end else begin
        check("ld data vec", WriteData, tbl[i].exp);
      end
    end
    mem_valid = 1'b0;
    clock_and_check("ld idle");
    check("err pulse end", 64'(load_err), 64'd0);

    // Write to x0 is accepted but dropped
    cnt_before = int'(wb_count);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
    clock_and_check("x0");
    check("x0 nowrite", 64'(RegWrite), 64'd0);
    check("x0 cnt", 64'(wb_count), 64'(cnt_before));
    alu_valid = 1'b0;

    // Async reset in the middle of a burst
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h55;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_funct3 = 3'b011; mem_addr_lo = 3'd0; mem_rdata = 64'h66;
    repeat (3) clock_and_check("burst");
    #2 reset = 1'b1;
    #1;
    check("areset RegWrite", 64'(RegWrite), 64'd0);
    check("areset RD", 64'(RD), 64'd0);
    check("areset WriteData", WriteData, 64'd0);
    check("areset wb_count", 64'(wb_count), 64'd0);
    check("areset alu_ready", 64'(alu_ready), 64'd1);
    check("areset mem_ready", 64'(mem_ready), 64'd0);
    model_reset();
    alu_valid = 1'b0; mem_valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    alu_valid = 1'b1; mem_valid = 1'b1;
    clock_and_check("tie after reset");
    check("tie after reset RD", 64'(RD), 64'd9);
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Randomized traffic with stable payload while waiting for ready
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid || m_acc_alu) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        alu_data  = {$urandom, $urandom};
      end
      if (!mem_valid || m_acc_mem) begin
        mem_valid   = 1'($urandom_range(0, 1));
        mem_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        mem_rdata   = {$urandom, $urandom};
        mem_funct3  = 3'($urandom);
        mem_addr_lo = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
      end
      clock_and_check("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
